// File: rtl/player_physics.sv
// Per-frame player motion engine: one-pixel stepping against collision flags plus PLAY/DEAD/WON state.
// Optional PLAYER_PHYSICS_DOUBLE_JUMP_EN grants one extra airborne jump per airtime.
module player_physics #(
    parameter int START_X      = 20,
    parameter int START_Y      = 344,
    parameter int RUN_SPEED    = 2,
    parameter int JUMP_VEL     = 10,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL     = 8,
    parameter int DEATH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       on_ground,
    input  logic       hit_ceiling,
    input  logic       hit_left_wall,
    input  logic       hit_right_wall,
    input  logic       at_goal_region,
    input  logic       in_lava,
    input  logic [9:0] support_y,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic [1:0] game_state,
    output logic       dead_pulse,
    output logic       win_pulse
);
    typedef enum logic [2:0] {IDLE, H_MOVE, H_CHK, V_MOVE, V_CHK, EVAL, DEAD, WON} state_t;

    localparam int HW = $clog2(RUN_SPEED + 1);
    localparam int DW = $clog2(DEATH_FRAMES + 1);
    localparam logic [9:0] X_MAX = 10'd623;

    state_t            state;
    logic signed [5:0] vy;
    logic [HW-1:0]     hsteps;
    logic [5:0]        vsteps;
    logic [DW-1:0]     death_cnt;
    logic              dir_left, v_down, v_cont, jump_req, btn_jump_q;
`ifdef PLAYER_PHYSICS_DOUBLE_JUMP_EN
    logic              air_used;
`endif

    logic signed [6:0] vy_grav;
    logic [5:0]        vy_abs;
    logic [9:0]        snap_y;
    logic              respawn;

    assign vy_grav = 7'(vy) + 7'(GRAVITY);
    assign vy_abs  = vy[5] ? 6'(-vy) : 6'(vy);
    assign snap_y  = support_y - 10'd16;
    assign respawn = (state == DEAD && frame_tick && death_cnt == DW'(DEATH_FRAMES - 1)) ||
                     (state == WON && jump_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            player_x   <= 10'(START_X);
            player_y   <= 10'(START_Y);
            vy         <= '0;
            hsteps     <= '0;
            vsteps     <= '0;
            death_cnt  <= '0;
            dir_left   <= 1'b0;
            v_down     <= 1'b0;
            v_cont     <= 1'b0;
            jump_req   <= 1'b0;
            btn_jump_q <= 1'b0;
            game_state <= 2'd0;
            dead_pulse <= 1'b0;
            win_pulse  <= 1'b0;
`ifdef PLAYER_PHYSICS_DOUBLE_JUMP_EN
            air_used   <= 1'b0;
`endif
        end else begin
            dead_pulse <= 1'b0;
            win_pulse  <= 1'b0;
            btn_jump_q <= btn_jump;
            if (btn_jump && !btn_jump_q)
                jump_req <= 1'b1;

            case (state)
                IDLE: if (frame_tick && game_state == 2'd0) begin
                    hsteps <= HW'(RUN_SPEED);
                    if (btn_left ^ btn_right) begin
                        dir_left <= btn_left;
                        state    <= H_MOVE;
                    end else begin
                        state <= V_MOVE;
                    end
                end
                H_MOVE: begin
                    // A step that would leave the screen ends horizontal motion for this frame.
                    if (dir_left ? (player_x == 10'd0) : (player_x == X_MAX)) begin
                        state <= V_MOVE;
                    end else begin
                        player_x <= dir_left ? player_x - 10'd1 : player_x + 10'd1;
                        state    <= H_CHK;
                    end
                end
                H_CHK: begin
                    if (dir_left ? hit_left_wall : hit_right_wall) begin
                        player_x <= dir_left ? player_x + 10'd1 : player_x - 10'd1;
                        state    <= V_MOVE;
                    end else begin
                        hsteps <= hsteps - HW'(1);
                        state  <= (hsteps == HW'(1)) ? V_MOVE : H_MOVE;
                    end
                end
                V_MOVE: begin
                    if (v_cont) begin
                        v_cont   <= 1'b0;
                        player_y <= v_down ? player_y + 10'd1 : player_y - 10'd1;
                        state    <= V_CHK;
                    end else if (!vy[5] && on_ground) begin
                        player_y <= snap_y;
                        vy       <= '0;
                        state    <= EVAL;
                    end else if (vy == 6'sd0) begin
                        state <= EVAL;
                    end else begin
                        vsteps   <= vy_abs;
                        v_down   <= !vy[5];
                        player_y <= vy[5] ? player_y - 10'd1 : player_y + 10'd1;
                        state    <= V_CHK;
                    end
                end
                V_CHK: begin
                    if (v_down && on_ground) begin
                        player_y <= snap_y;
                        vy       <= '0;
                        state    <= EVAL;
                    end else if (!v_down && hit_ceiling) begin
                        player_y <= player_y + 10'd1;
                        vy       <= '0;
                        state    <= EVAL;
                    end else if (vsteps == 6'd1) begin
                        state <= EVAL;
                    end else begin
                        vsteps <= vsteps - 6'd1;
                        v_cont <= 1'b1;
                        state  <= V_MOVE;
                    end
                end
                EVAL: begin
                    jump_req <= 1'b0;
                    if (in_lava) begin
                        state      <= DEAD;
                        game_state <= 2'd1;
                        dead_pulse <= 1'b1;
                        death_cnt  <= '0;
                    end else if (at_goal_region) begin
                        state      <= WON;
                        game_state <= 2'd2;
                        win_pulse  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        if (on_ground && jump_req)
                            vy <= -6'(JUMP_VEL);
`ifdef PLAYER_PHYSICS_DOUBLE_JUMP_EN
                        else if (!on_ground && jump_req && !air_used) begin
                            vy       <= -6'(JUMP_VEL);
                            air_used <= 1'b1;
                        end
`endif
                        else if (!on_ground)
                            vy <= (vy_grav > 7'(MAX_FALL)) ? 6'(MAX_FALL) : vy_grav[5:0];
`ifdef PLAYER_PHYSICS_DOUBLE_JUMP_EN
                        if (on_ground)
                            air_used <= 1'b0;
`endif
                    end
                end
                DEAD: if (frame_tick) death_cnt <= death_cnt + DW'(1);
                default: ;
            endcase

            // Respawn overrides whatever the state case scheduled this cycle.
            if (respawn) begin
                state      <= IDLE;
                player_x   <= 10'(START_X);
                player_y   <= 10'(START_Y);
                vy         <= '0;
                jump_req   <= 1'b0;
                v_cont     <= 1'b0;
                death_cnt  <= '0;
                game_state <= 2'd0;
`ifdef PLAYER_PHYSICS_DOUBLE_JUMP_EN
                air_used   <= 1'b0;
`endif
            end
        end
    end
endmodule
